// File: rtl/pdm_pkg.sv
// Shared constants for the PDM microphone peripheral: sample width, FIFO depth
// and the CPU-visible register map.
package pdm_pkg;

   localparam int PCM_WIDTH      = 16;
   localparam int PDM_FIFO_DEPTH = 16;

   localparam logic [7:0] REG_CTRL        = 8'h00;
   localparam logic [7:0] REG_CLKP        = 8'h04;
   localparam logic [7:0] REG_FIFO_DATA   = 8'h08;
   localparam logic [7:0] REG_FIFO_STATUS = 8'h0C;
   localparam logic [7:0] REG_WATERMARK   = 8'h10;

   // Field order of the status register, MSB first.
   typedef struct packed {
      logic       overflow;
      logic       underflow;
      logic       full;
      logic       empty;
      logic [4:0] level;
   } fifo_status_t;

   function automatic int fifo_level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pdm_pcm_fifo_if.sv
// Bundle between the decimator/CPU register block and the PCM sample FIFO.
interface pdm_pcm_fifo_if
   import pdm_pkg::*;
#(
   parameter int WIDTH = PCM_WIDTH,
   parameter int LW    = fifo_level_width(PDM_FIFO_DEPTH)
);

   logic             enable;
   logic [WIDTH-1:0] pcm_in;
   logic             pcm_valid_in;
   logic             pop;
   logic             clear;
   logic [LW-1:0]    watermark;
   logic [WIDTH-1:0] rd_data;
   logic [LW-1:0]    level;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;
   logic             irq;

   modport master (
      output enable, pcm_in, pcm_valid_in, pop, clear, watermark,
      input  rd_data, level, empty, full, overflow, underflow, irq
   );

   modport slave (
      input  enable, pcm_in, pcm_valid_in, pop, clear, watermark,
      output rd_data, level, empty, full, overflow, underflow, irq
   );

endinterface

// File: rtl/pdm_fifo_mem.sv
// Sample storage: register array with one synchronous write port and an
// asynchronous read port so the FIFO head is visible without latency.
module pdm_fifo_mem #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents survive reset and clear; the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pdm_pcm_fifo.sv
// Show-ahead PCM sample FIFO behind the CIC3 decimator, with sticky
// overflow/underflow flags and a watermark interrupt.
module pdm_pcm_fifo
   import pdm_pkg::*;
#(
   parameter int DEPTH = PDM_FIFO_DEPTH,
   parameter int WIDTH = PCM_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   pdm_pcm_fifo_if.slave    bus
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int AW = LW - 1;

   logic [LW-1:0]    wr_ptr;
   logic [LW-1:0]    rd_ptr;
   logic [LW-1:0]    wr_ptr_nxt;
   logic [LW-1:0]    rd_ptr_nxt;
   logic [LW-1:0]    level_q;
   logic             overflow_q;
   logic             underflow_q;
   logic             empty;
   logic             full;
   logic             pop_ok;
   logic             push_req;
   logic             push_ok;
   logic [WIDTH-1:0] mem_rd;

   assign empty    = (level_q == '0);
   assign full     = (level_q == LW'(DEPTH));
   assign pop_ok   = bus.pop & ~empty;
   assign push_req = bus.enable & bus.pcm_valid_in;
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign push_ok  = push_req & (~full | pop_ok);

   assign wr_ptr_nxt = push_ok ? wr_ptr + LW'(1) : wr_ptr;
   assign rd_ptr_nxt = pop_ok  ? rd_ptr + LW'(1) : rd_ptr;

   // Pointers wrap modulo 2*DEPTH so their difference distinguishes full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.clear) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr  <= wr_ptr_nxt;
         rd_ptr  <= rd_ptr_nxt;
         level_q <= wr_ptr_nxt - rd_ptr_nxt;
         if (push_req & ~push_ok) begin
            overflow_q <= 1'b1;
         end
         if (bus.pop & empty) begin
            underflow_q <= 1'b1;
         end
      end
   end

   pdm_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push_ok & ~bus.clear),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (bus.pcm_in),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (mem_rd)
   );

   assign bus.rd_data   = empty ? '0 : mem_rd;
   assign bus.level     = level_q;
   assign bus.empty     = empty;
   assign bus.full      = full;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
   assign bus.irq       = ((bus.watermark != '0) && (level_q >= bus.watermark)) || overflow_q;

endmodule

// File: tb/tb_pdm_pcm_fifo.sv
// Self-checking bench for pdm_pcm_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_pdm_pcm_fifo;

   localparam int DEPTH = 16;
   localparam int WIDTH = 16;
   localparam int LW    = 5;

   logic clk;
   logic rst_n;

   int checks   = 0;
   int failures = 0;

   int mdl_q[$];
   bit mdl_ovf;
   bit mdl_udf;

   pdm_pcm_fifo_if #(.WIDTH(WIDTH), .LW(LW)) bus ();

   pdm_pcm_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference: a plain queue of samples, pops taken from the front before the push lands.
   task automatic modelStep(input bit en, input bit valid, input int data, input bit pp, input bit clr);
      bit pop_ok;
      if (clr) begin
         mdl_q.delete();
         mdl_ovf = 0;
         mdl_udf = 0;
      end else begin
         pop_ok = pp && (mdl_q.size() > 0);
         if (pp && mdl_q.size() == 0) mdl_udf = 1;
         if (en && valid && !(mdl_q.size() < DEPTH || pop_ok)) mdl_ovf = 1;
         else if (en && valid) begin
            if (pop_ok) void'(mdl_q.pop_front());
            mdl_q.push_back(data);
            pop_ok = 0;
         end
         if (pop_ok) void'(mdl_q.pop_front());
      end
   endtask

   task automatic checkAll(input string tag);
      int lvl;
      int wm;
      int head;
      lvl  = mdl_q.size();
      wm   = int'(bus.watermark);
      head = (lvl > 0) ? mdl_q[0] : 0;
      checkOutput({tag, ".level"},     32'(bus.level),     32'(lvl));
      checkOutput({tag, ".empty"},     32'(bus.empty),     32'(lvl == 0));
      checkOutput({tag, ".full"},      32'(bus.full),      32'(lvl == DEPTH));
      checkOutput({tag, ".overflow"},  32'(bus.overflow),  32'(mdl_ovf));
      checkOutput({tag, ".underflow"}, 32'(bus.underflow), 32'(mdl_udf));
      checkOutput({tag, ".rd_data"},   32'(bus.rd_data),   32'(head));
      checkOutput({tag, ".irq"},       32'(bus.irq),       32'(((wm != 0) && (lvl >= wm)) || mdl_ovf));
   endtask

   task automatic setIdle();
      bus.enable       = 1'b0;
      bus.pcm_valid_in = 1'b0;
      bus.pcm_in       = '0;
      bus.pop          = 1'b0;
      bus.clear        = 1'b0;
   endtask

   // Drives one cycle of inputs, lets one rising edge consume them, then checks just after.
   task automatic applyStimulus(input string tag, input bit en, input bit valid, input logic [15:0] data,
                                input bit pp, input bit clr);
      bus.enable       = en;
      bus.pcm_valid_in = valid;
      bus.pcm_in       = data;
      bus.pop          = pp;
      bus.clear        = clr;
      @(posedge clk);
      modelStep(en, valid, int'(data), pp, clr);
      #1;
      checkAll(tag);
   endtask

   task automatic doPush(input string tag, input logic [15:0] data);
      applyStimulus(tag, 1'b1, 1'b1, data, 1'b0, 1'b0);
   endtask

   task automatic doPop(input string tag);
      applyStimulus(tag, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
   endtask

   task automatic doClear(input string tag);
      applyStimulus(tag, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.watermark = '0;
      setIdle();
      mdl_q.delete();
      mdl_ovf = 0;
      mdl_udf = 0;
      #12;
      checkAll("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic ordering.
      doPush("p1", 16'h1111);
      doPush("p2", 16'h2222);
      doPush("p3", 16'h3333);
      checkOutput("three.level", 32'(bus.level), 32'd3);
      checkOutput("three.head", 32'(bus.rd_data), 32'h1111);
      doPop("pop1");
      checkOutput("pop1.head", 32'(bus.rd_data), 32'h2222);
      doPop("pop2");
      checkOutput("pop2.head", 32'(bus.rd_data), 32'h3333);
      doPop("pop3");
      checkOutput("drained.empty", 32'(bus.empty), 32'd1);
      checkOutput("drained.rd_data", 32'(bus.rd_data), 32'd0);

      // Overflow: 17 pushes, the last one dropped.
      for (int i = 0; i <= 16; i++) begin
         doPush("ovf.push", 16'(i));
         if (i == 15) begin
            checkOutput("ovf.full16", 32'(bus.full), 32'd1);
            checkOutput("ovf.level16", 32'(bus.level), 32'd16);
         end
      end
      checkOutput("ovf.flag", 32'(bus.overflow), 32'd1);
      checkOutput("ovf.irq", 32'(bus.irq), 32'd1);
      for (int i = 0; i < 16; i++) begin
         checkOutput("ovf.drain", 32'(bus.rd_data), 32'(i));
         doPop("ovf.pop");
      end
      checkOutput("ovf.lost", 32'(bus.empty), 32'd1);
      doClear("ovf.clear");

      // Push and pop together while full.
      for (int i = 0; i < 16; i++) doPush("fp.fill", 16'(16'h0100 + i));
      applyStimulus("fp.both", 1'b1, 1'b1, 16'hAAAA, 1'b1, 1'b0);
      checkOutput("fp.level", 32'(bus.level), 32'd16);
      checkOutput("fp.noovf", 32'(bus.overflow), 32'd0);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) checkOutput("fp.last", 32'(bus.rd_data), 32'hAAAA);
         doPop("fp.drain");
      end

      // Watermark interrupt.
      bus.watermark = 5'd4;
      for (int i = 0; i < 3; i++) doPush("wm.push", 16'(16'h0200 + i));
      checkOutput("wm.below", 32'(bus.irq), 32'd0);
      doPush("wm.push4", 16'h0203);
      checkOutput("wm.at", 32'(bus.irq), 32'd1);
      doPop("wm.pop");
      checkOutput("wm.after_pop", 32'(bus.irq), 32'd0);
      bus.watermark = 5'd0;
      #1;
      checkAll("wm.zero");
      for (int i = 0; i < 13; i++) doPush("wm0.push", 16'(16'h0300 + i));
      checkOutput("wm0.full", 32'(bus.level), 32'd16);
      checkOutput("wm0.irq", 32'(bus.irq), 32'd0);
      bus.watermark = 5'd17;
      #1;
      checkOutput("wm17.irq", 32'(bus.irq), 32'd0);
      bus.watermark = 5'd16;
      #1;
      checkOutput("wm16.irq", 32'(bus.irq), 32'd1);
      bus.watermark = 5'd0;
      doClear("wm.clear");

      // Underflow and empty push+pop.
      doPop("uf.pop");
      checkOutput("uf.flag", 32'(bus.underflow), 32'd1);
      checkOutput("uf.level", 32'(bus.level), 32'd0);
      applyStimulus("uf.both", 1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b0);
      checkOutput("uf.both.level", 32'(bus.level), 32'd1);
      checkOutput("uf.both.data", 32'(bus.rd_data), 32'h5A5A);
      applyStimulus("clr.prio", 1'b1, 1'b1, 16'h7777, 1'b1, 1'b1);
      checkOutput("clr.level", 32'(bus.level), 32'd0);
      checkOutput("clr.uf", 32'(bus.underflow), 32'd0);
      checkOutput("clr.ovf", 32'(bus.overflow), 32'd0);

      // Asynchronous reset in the middle of a burst.
      bus.watermark = 5'd2;
      for (int i = 0; i < 5; i++) doPush("ar.push", 16'(16'h0400 + i));
      setIdle();
      #2;
      rst_n = 1'b0;
      #1;
      mdl_q.delete();
      mdl_ovf = 0;
      mdl_udf = 0;
      checkAll("ar.async");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Disabled capture ignores strobes; stored data stays readable.
      for (int i = 0; i < 4; i++) applyStimulus("dis.push", 1'b0, 1'b1, 16'(16'h0500 + i), 1'b0, 1'b0);
      checkOutput("dis.level", 32'(bus.level), 32'd0);
      doPush("dis.pre", 16'h0600);
      applyStimulus("dis.pop", 1'b0, 1'b1, 16'h0601, 1'b1, 1'b0);

      // Randomized traffic.
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 49) == 0) bus.watermark = 5'($urandom_range(0, 31));
         applyStimulus("rand",
                       $urandom_range(0, 3) != 0,
                       $urandom_range(0, 1) == 1,
                       16'($urandom),
                       $urandom_range(0, 9) < 4,
                       $urandom_range(0, 59) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
